// File: rtl/tpu_result_drain.sv
// Result SRAM drain: on a rising end_, sweeps base..base+num_rows-1 and streams
// each row to the host through a 2-entry skid FIFO with credit-gated reads.
module tpu_result_drain #(
  parameter int ADDRESSSIZE    = 10,
  parameter int MATRIX_SIZE    = 8,
  parameter int PARTIAL_SUM_BW = 20
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   end_,
  input  logic [ADDRESSSIZE-1:0]                 base_addr,
  input  logic [ADDRESSSIZE:0]                   num_rows,
  output logic                                   res_rd_en,
  output logic [ADDRESSSIZE-1:0]                 res_addr,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  res_data,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  m_data,
  output logic                                   m_last,
  output logic                                   busy,
  output logic                                   done
);
  localparam int RW = PARTIAL_SUM_BW*MATRIX_SIZE;

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;
  typedef struct packed {
    logic          last;
    logic [RW-1:0] data;
  } row_t;

  state_t                 state, state_nxt;
  logic                   end_q, trigger;
  logic [ADDRESSSIZE-1:0] rd_addr;
  logic [ADDRESSSIZE:0]   remaining;
  logic                   rd_pend, rd_pend_last;
  logic                   rd_en, last_rd, push, pop;
  row_t                   fifo [2];
  logic                   wr_ptr, rd_ptr;
  logic [1:0]             occ;
  logic [2:0]             inflight;

  assign trigger  = end_ & ~end_q;
  assign push     = rd_pend;
  assign pop      = m_valid & m_ready;
  // Rows already buffered plus the read in flight, net of this cycle's pop.
  assign inflight = {1'b0, occ} + {2'b0, rd_pend} - {2'b0, pop};
  assign rd_en    = (state == READ) && (inflight < 3'd2);
  assign last_rd  = rd_en && (remaining == (ADDRESSSIZE+1)'(1));

  assign res_rd_en = rd_en;
  assign res_addr  = rd_addr;
  assign m_valid   = (occ != 2'd0);
  assign m_data    = m_valid ? fifo[rd_ptr].data : '0;
  assign m_last    = m_valid & fifo[rd_ptr].last;
  assign busy      = (state == READ) || (state == FLUSH);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:  if (trigger) state_nxt = (num_rows == '0) ? DONE : READ;
      READ:  if (last_rd) state_nxt = FLUSH;
      FLUSH: if (pop && m_last) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      end_q <= 1'b0;
    end else begin
      state <= state_nxt;
      end_q <= end_;
    end
  end

  // Address/count sweep; a trigger outside IDLE never reloads them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_addr      <= '0;
      remaining    <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      if (state == IDLE && trigger) begin
        rd_addr   <= base_addr;
        remaining <= num_rows;
      end else if (rd_en) begin
        rd_addr   <= rd_addr + ADDRESSSIZE'(1);
        remaining <= remaining - (ADDRESSSIZE+1)'(1);
      end
      rd_pend      <= rd_en;
      rd_pend_last <= last_rd;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= '{last: rd_pend_last, data: res_data};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: tb/tb_tpu_result_drain.sv
// Scoreboard bench for tpu_result_drain: SRAM model, address/row queues,
// backpressure driver, timing checks around trigger, wrap, zero-length, reset.
module tb_tpu_result_drain;
  localparam int AW = 10;
  localparam int MS = 8;
  localparam int PW = 20;
  localparam int RW = MS*PW;

  typedef struct {
    logic [RW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn, end_, m_ready;
  logic [AW-1:0] base_addr, res_addr;
  logic [AW:0]   num_rows;
  logic          res_rd_en, m_valid, m_last, busy, done;
  logic [RW-1:0] res_data, m_data;

  tpu_result_drain #(.ADDRESSSIZE(AW), .MATRIX_SIZE(MS), .PARTIAL_SUM_BW(PW)) dut (
    .clk(clk), .rstn(rstn), .end_(end_), .base_addr(base_addr), .num_rows(num_rows),
    .res_rd_en(res_rd_en), .res_addr(res_addr), .res_data(res_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [RW-1:0] sram [1<<AW];
  always @(posedge clk) if (res_rd_en) res_data <= sram[res_addr];

  int            n_checks = 0, n_err = 0;
  int            cyc = 0, e0_cyc = 0, seed = 0;
  int            rd_issued = 0, hs_cnt = 0, done_cnt = 0, done_cyc = 0;
  int            first_hs_cyc = 0, last_hs_cyc = 0;
  logic [AW-1:0] addr_q[$];
  exp_t          exp_q[$];
  exp_t          mon_e;
  logic          prev_stall = 1'b0;
  logic [RW-1:0] prev_data = '0;
  logic          bp_en = 1'b0;
  logic [3:0]    bp_pat = 4'b1001;
  int            bp_ph = 0;

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] pattern(input logic [AW-1:0] a, input int s);
    logic [RW-1:0] r;
    for (int j = 0; j < MS; j++) r[j*PW +: PW] = PW'(int'(a)*131 + j*4099 + s*7919 + 1);
    return r;
  endfunction

  task automatic preload(input int s);
    seed = s;
    for (int a = 0; a < (1<<AW); a++) sram[a] = pattern(AW'(a), s);
  endtask

  always @(posedge clk) cyc++;

  // m_ready: held high unless the 1,0,0,1 backpressure pattern is enabled.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = bp_en ? bp_pat[bp_ph] : 1'b1;
      if (bp_en) bp_ph = (bp_ph + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (res_rd_en) begin
      chk("credit", RW'((rd_issued - hs_cnt - int'(m_valid && m_ready)) < 2), RW'(1));
      rd_issued++;
      chk("rd_expected", RW'(addr_q.size() != 0), RW'(1));
      if (addr_q.size() != 0) chk("rd_addr", RW'(res_addr), RW'(addr_q.pop_front()));
    end
    if (m_valid && m_ready) begin
      chk("row_expected", RW'(exp_q.size() != 0), RW'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("row_data", m_data, mon_e.data);
        chk("row_last", RW'(m_last), RW'(mon_e.last));
      end
      if (hs_cnt == 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      hs_cnt++;
    end
    if (prev_stall) begin
      chk("hold_valid", RW'(m_valid), RW'(1));
      chk("hold_data", m_data, prev_data);
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic kick(input logic [AW-1:0] b, input logic [AW:0] n);
    exp_t x;
    logic [AW-1:0] a;
    @(posedge clk); #1;
    base_addr = b;
    num_rows  = n;
    rd_issued = 0; hs_cnt = 0; done_cnt = 0;
    for (int k = 0; k < int'(n); k++) begin
      a = b + AW'(k);
      addr_q.push_back(a);
      x.data = pattern(a, seed);
      x.last = (k == int'(n) - 1);
      exp_q.push_back(x);
    end
    end_ = 1'b1;
    @(posedge clk); #1;
    e0_cyc = cyc;
    end_ = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (done_cnt == 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", RW'(done_cnt != 0), RW'(1));
    repeat (4) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, RW'(res_rd_en), RW'(0));
    chk({tag, "_addr"},  RW'(res_addr),  RW'(0));
    chk({tag, "_valid"}, RW'(m_valid),   RW'(0));
    chk({tag, "_data"},  m_data,         RW'(0));
    chk({tag, "_last"},  RW'(m_last),    RW'(0));
    chk({tag, "_busy"},  RW'(busy),      RW'(0));
    chk({tag, "_done"},  RW'(done),      RW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; end_ = 1'b0; base_addr = '0; num_rows = '0;
    preload(1);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Basic drain: back-to-back rows, fixed latency from the trigger edge.
    kick(10'd0, 11'd8);
    @(negedge clk);
    chk("first_rd_en", RW'(res_rd_en), RW'(1));
    chk("first_addr", RW'(res_addr), RW'(0));
    chk("busy_on", RW'(busy), RW'(1));
    @(negedge clk);
    chk("valid_after_e1", RW'(m_valid), RW'(0));
    @(negedge clk);
    chk("valid_after_e2", RW'(m_valid), RW'(1));
    wait_done(40);
    chk("basic_rows", RW'(hs_cnt), RW'(8));
    chk("basic_burst", RW'(last_hs_cyc - first_hs_cyc), RW'(7));
    chk("basic_done_lat", RW'(done_cyc - e0_cyc), RW'(10));
    chk("done_after_hs", RW'(done_cyc), RW'(last_hs_cyc + 1));
    chk("basic_done_once", RW'(done_cnt), RW'(1));
    chk("basic_busy_off", RW'(busy), RW'(0));
    chk("basic_sb_empty", RW'(exp_q.size()), RW'(0));

    // Backpressure with m_ready 1,0,0,1.
    preload(2);
    bp_ph = 0; bp_en = 1'b1;
    kick(10'd0, 11'd8);
    wait_done(120);
    bp_en = 1'b0;
    chk("bp_rows", RW'(hs_cnt), RW'(8));
    chk("bp_done_once", RW'(done_cnt), RW'(1));
    chk("bp_sb_empty", RW'(exp_q.size()), RW'(0));

    // Wrap at the top of the address space.
    preload(3);
    kick(10'd1020, 11'd8);
    wait_done(40);
    chk("wrap_rows", RW'(hs_cnt), RW'(8));
    chk("wrap_addr_empty", RW'(addr_q.size()), RW'(0));
    chk("wrap_sb_empty", RW'(exp_q.size()), RW'(0));

    // Zero length: no reads, no rows, a single done shortly after the trigger.
    kick(10'd5, 11'd0);
    for (int i = 0; i < 4; i++) begin
      chk("zero_no_rd", RW'(res_rd_en), RW'(0));
      chk("zero_no_valid", RW'(m_valid), RW'(0));
      chk("zero_no_busy", RW'(busy), RW'(0));
      @(negedge clk);
    end
    chk("zero_done_once", RW'(done_cnt), RW'(1));
    chk("zero_done_lat", RW'((done_cyc - e0_cyc) <= 2), RW'(1));

    // Retrigger mid-drain is ignored.
    preload(4);
    kick(10'd40, 11'd8);
    @(posedge clk); #1; end_ = 1'b1;
    @(posedge clk); #1; end_ = 1'b0;
    wait_done(40);
    repeat (6) @(negedge clk);
    chk("retrig_rows", RW'(hs_cnt), RW'(8));
    chk("retrig_done_once", RW'(done_cnt), RW'(1));
    chk("retrig_rd_count", RW'(rd_issued), RW'(8));
    chk("retrig_sb_empty", RW'(exp_q.size()), RW'(0));

    // Reset mid-drain, then a fresh drain from the same base.
    preload(5);
    kick(10'd100, 11'd8);
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_idle_outputs("midrst");
    addr_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    kick(10'd100, 11'd8);
    @(negedge clk);
    chk("restart_rd_en", RW'(res_rd_en), RW'(1));
    chk("restart_addr", RW'(res_addr), RW'(100));
    wait_done(40);
    chk("restart_rows", RW'(hs_cnt), RW'(8));
    chk("restart_done_once", RW'(done_cnt), RW'(1));
    chk("restart_sb_empty", RW'(exp_q.size()), RW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
